speech256_allo_sequencer: RTL and testbench

//   Host-side allophone queue and load controller for the SPEECH256 core.

---
 rtl/speech256_pkg.sv | 13 +
 rtl/speech256_allo_sequencer_if.sv | 29 ++
 rtl/speech256_allo_fifo.sv | 55 +++++
 rtl/speech256_allo_sequencer.sv | 109 ++++++++++
 tb/tb_speech256_allo_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/speech256_pkg.sv
// Shared types and widths for the SPEECH256 host-side allophone sequencer.
package speech256_pkg;

   localparam int ALLO_W = 6;

   typedef enum logic [1:0] {
      IDLE,
      STROBE,
      WAIT_ACK,
      WAIT_READY
   } seq_state_t;

endpackage

// File: rtl/speech256_allo_sequencer_if.sv
// Host queue and core load-port bundle; slave is the sequencer's view.
interface speech256_allo_sequencer_if
   import speech256_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
);
   logic [ALLO_W-1:0]           host_data;
   logic                        host_wr;
   logic                        flush;
   logic                        clr_err;
   logic                        host_full;
   logic [$clog2(FIFO_DEPTH):0] host_level;
   logic                        ldq;
   logic [ALLO_W-1:0]           data_in;
   logic                        data_stb;
   logic                        busy;
   logic                        err_overflow;
   logic                        err_timeout;

   modport slave (
      input  host_data, host_wr, flush, clr_err, ldq,
      output host_full, host_level, data_in, data_stb, busy, err_overflow, err_timeout
   );

   modport master (
      output host_data, host_wr, flush, clr_err, ldq,
      input  host_full, host_level, data_in, data_stb, busy, err_overflow, err_timeout
   );
endinterface

// File: rtl/speech256_allo_fifo.sv
// Synchronous allophone FIFO with exact fill level; flush beats a same-cycle write.
module speech256_allo_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 6
) (
   input  logic                    clk,
   input  logic                    rst_an,
   input  logic                    wr,
   input  logic [W-1:0]            wr_data,
   input  logic                    rd,
   input  logic                    flush,
   output logic [W-1:0]            rd_data,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   // a pop frees the slot the same-cycle write lands in, so writes are legal even when full
   assign do_rd = rd && !empty && !flush;
   assign do_wr = wr && (!full || do_rd) && !flush;

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_wr && !do_rd)      level <= level + LVL_W'(1);
         else if (!do_wr && do_rd) level <= level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));

endmodule

// File: rtl/speech256_allo_sequencer.sv
// Allophone sequencer: drains the host FIFO into the SPEECH256 core over the ldq handshake.
//   state      | meaning
//   IDLE       | waiting for a queued allophone while ldq=1
//   STROBE     | data_stb high for this single cycle
//   WAIT_ACK   | waiting for the core to drop ldq, bounded by ACK_TIMEOUT
//   WAIT_READY | waiting for the core to raise ldq again
module speech256_allo_sequencer
   import speech256_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic                       clk,
   input  logic                       rst_an,
   speech256_allo_sequencer_if.slave  bus
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   seq_state_t        state;
   seq_state_t        state_nxt;
   logic              pop;
   logic              timeout_hit;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LVL_W-1:0]  fifo_level;
   logic [ALLO_W-1:0] fifo_head;
   logic [CNT_W-1:0]  ack_cnt;
   logic              ldq_q;
   logic [ALLO_W-1:0] data_in_r;
   logic              data_stb_r;
   logic              err_ovf_r;
   logic              err_tmo_r;

   speech256_allo_fifo #(.DEPTH(FIFO_DEPTH), .W(ALLO_W)) u_fifo (
      .clk     (clk),
      .rst_an  (rst_an),
      .wr      (bus.host_wr),
      .wr_data (bus.host_data),
      .rd      (pop),
      .flush   (bus.flush),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) state <= IDLE;
      else         state <= state_nxt;
   end

   // WAIT_READY leaves on a rising ldq, so a timed-out strobe still needs a low-high toggle
   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && bus.ldq && !bus.flush) begin
               pop       = 1'b1;
               state_nxt = STROBE;
            end
         end
         STROBE:   state_nxt = WAIT_ACK;
         WAIT_ACK: begin
            if (!bus.ldq) begin
               state_nxt = WAIT_READY;
            end else if (ack_cnt == CNT_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = WAIT_READY;
            end
         end
         WAIT_READY: if (bus.ldq && !ldq_q) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         ack_cnt    <= '0;
         ldq_q      <= 1'b0;
         data_in_r  <= '0;
         data_stb_r <= 1'b0;
         err_ovf_r  <= 1'b0;
         err_tmo_r  <= 1'b0;
      end else begin
         ldq_q      <= bus.ldq;
         data_stb_r <= pop;
         if (pop) data_in_r <= fifo_head;
         if (state == STROBE)                 ack_cnt <= '0;
         else if (state == WAIT_ACK && bus.ldq) ack_cnt <= ack_cnt + CNT_W'(1);
         if (bus.host_wr && fifo_full && !pop) err_ovf_r <= 1'b1;
         else if (bus.clr_err)                 err_ovf_r <= 1'b0;
         if (timeout_hit)                      err_tmo_r <= 1'b1;
         else if (bus.clr_err)                 err_tmo_r <= 1'b0;
      end
   end

   assign bus.host_full    = fifo_full;
   assign bus.host_level   = fifo_level;
   assign bus.data_in      = data_in_r;
   assign bus.data_stb     = data_stb_r;
   assign bus.busy         = !fifo_empty || (state != IDLE);
   assign bus.err_overflow = err_ovf_r;
   assign bus.err_timeout  = err_tmo_r;

endmodule

// File: tb/tb_speech256_allo_sequencer.sv
// Directed scenarios plus a random soak against a queue-based reference model.
module tb_speech256_allo_sequencer;
   import speech256_pkg::*;

   localparam int DEPTH = 16;
   localparam int TMO   = 1023;

   logic clk    = 1'b0;
   logic rst_an = 1'b0;
   always #5 clk = ~clk;

   speech256_allo_sequencer_if #(.FIFO_DEPTH(DEPTH)) bus ();

   speech256_allo_sequencer #(.FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)) dut (
      .clk    (clk),
      .rst_an (rst_an),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;

   // reference model: queue contents plus the handshake phase of the last strobe
   int q[$];
   bit m_stb, m_rel, m_rearm, m_seen_low, m_ov, m_to;
   int m_wait, m_din;

   task automatic check_val(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_stb = 0; m_rel = 0; m_rearm = 0; m_seen_low = 0;
      m_ov = 0; m_to = 0; m_wait = 0; m_din = 0;
   endfunction

   function automatic void model_edge(input bit wr, input int d, input bit fl, input bit l, input bit clr);
      bit full0, pop, ov, to;
      full0 = (q.size() == DEPTH);
      pop   = !m_stb && !m_rel && !m_rearm && (q.size() > 0) && l && !fl;
      ov    = wr && full0 && !pop;
      to    = 0;
      if (m_stb) begin
         m_stb = 0; m_rel = 1; m_wait = 0;
      end else if (m_rel) begin
         if (!l) begin
            m_rel = 0; m_rearm = 1; m_seen_low = 1;
         end else begin
            m_wait++;
            if (m_wait == TMO) begin
               to = 1; m_rel = 0; m_rearm = 1; m_seen_low = 0;
            end
         end
      end else if (m_rearm) begin
         if (!l)              m_seen_low = 1;
         else if (m_seen_low) m_rearm = 0;
      end
      if (fl) q.delete();
      else begin
         if (pop) begin
            m_din = q.pop_front();
            m_stb = 1;
         end
         if (wr && (!full0 || pop)) q.push_back(d);
      end
      m_ov = ov ? 1'b1 : (clr ? 1'b0 : m_ov);
      m_to = to ? 1'b1 : (clr ? 1'b0 : m_to);
   endfunction

   task automatic check_outputs();
      check_val("data_in",      int'(bus.data_in),      m_din);
      check_val("data_stb",     int'(bus.data_stb),     int'(m_stb));
      check_val("host_level",   int'(bus.host_level),   q.size());
      check_val("host_full",    int'(bus.host_full),    int'(q.size() == DEPTH));
      check_val("busy",         int'(bus.busy),         int'(q.size() > 0 || m_stb || m_rel || m_rearm));
      check_val("err_overflow", int'(bus.err_overflow), int'(m_ov));
      check_val("err_timeout",  int'(bus.err_timeout),  int'(m_to));
   endtask

   task automatic drive(input bit wr, input int d, input bit fl, input bit l, input bit clr);
      bus.host_wr   = wr;
      bus.host_data = d[5:0];
      bus.flush     = fl;
      bus.ldq       = l;
      bus.clr_err   = clr;
   endtask

   task automatic step();
      bit wr  = bus.host_wr;
      bit fl  = bus.flush;
      bit l   = bus.ldq;
      bit clr = bus.clr_err;
      int d   = int'(bus.host_data);
      @(posedge clk);
      model_edge(wr, d, fl, l, clr);
      #1;
      check_outputs();
   endtask

   initial begin
      int got[$];
      int exp3[3];
      int since, strobes, e_cyc, c, last_din;
      bit l;

      exp3 = '{5, 7, 12};
      drive(0, 0, 0, 0, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      rst_an = 1'b1;

      // single allophone latency
      drive(1, 7, 0, 1, 0); step();
      check_val("t2_level_n1", int'(bus.host_level), 1);
      check_val("t2_stb_n1", int'(bus.data_stb), 0);
      drive(0, 0, 0, 1, 0); step();
      check_val("t2_stb_n2", int'(bus.data_stb), 1);
      check_val("t2_din_n2", int'(bus.data_in), 7);
      check_val("t2_level_n2", int'(bus.host_level), 0);
      step();
      check_val("t2_stb_n3", int'(bus.data_stb), 0);

      // reset while in WAIT_ACK with entries queued
      drive(1, 9, 0, 1, 0);  step();
      drive(1, 11, 0, 1, 0); step();
      drive(0, 0, 0, 1, 0);  step();
      #2 rst_an = 1'b0;
      #1;
      check_val("rst_din",   int'(bus.data_in), 0);
      check_val("rst_stb",   int'(bus.data_stb), 0);
      check_val("rst_level", int'(bus.host_level), 0);
      check_val("rst_full",  int'(bus.host_full), 0);
      check_val("rst_busy",  int'(bus.busy), 0);
      check_val("rst_eov",   int'(bus.err_overflow), 0);
      check_val("rst_eto",   int'(bus.err_timeout), 0);
      model_reset();
      @(posedge clk);
      #1 rst_an = 1'b1;

      // burst with a core that acks 3 cycles after each strobe and re-arms 40 later
      since = -1;
      for (int i = 0; i < 200; i++) begin
         if (since >= 0) since++;
         l = !(since >= 3 && since < 43);
         drive(i < 3, (i < 3) ? exp3[i % 3] : 0, 0, l, 0);
         step();
         if (bus.data_stb) begin
            got.push_back(int'(bus.data_in));
            since = 0;
         end
      end
      check_val("t3_count", got.size(), 3);
      for (int k = 0; k < 3; k++)
         check_val("t3_order", (k < got.size()) ? got[k] : -1, exp3[k]);
      check_val("t3_busy_end", int'(bus.busy), 0);

      // fill, overflow, clear, then write+pop while full
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, $urandom_range(0, 63), 0, 0, 0); step();
      end
      check_val("t4_full", int'(bus.host_full), 1);
      check_val("t4_level16", int'(bus.host_level), DEPTH);
      drive(1, 3, 0, 0, 0); step();
      check_val("t4_ovf_set", int'(bus.err_overflow), 1);
      check_val("t4_level_hold", int'(bus.host_level), DEPTH);
      drive(0, 0, 0, 0, 1); step();
      check_val("t4_ovf_clr", int'(bus.err_overflow), 0);
      drive(1, 4, 0, 1, 0); step();
      check_val("t4_wrpop_ovf", int'(bus.err_overflow), 0);
      check_val("t4_wrpop_level", int'(bus.host_level), DEPTH);
      check_val("t4_wrpop_stb", int'(bus.data_stb), 1);
      drive(0, 0, 1, 0, 0); step();
      check_val("t4_flush_level", int'(bus.host_level), 0);
      drive(0, 0, 0, 0, 0); repeat (3) step();
      drive(0, 0, 0, 1, 0); repeat (3) step();

      // timeout: ldq never released
      drive(1, 33, 0, 1, 0); step();
      drive(0, 0, 0, 1, 0);  step();
      check_val("t5_stb", int'(bus.data_stb), 1);
      drive(1, 44, 0, 1, 0); step();
      c = 1; e_cyc = -1; strobes = 0;
      drive(0, 0, 0, 1, 0);
      for (int i = 0; i < 1100; i++) begin
         step();
         c++;
         if (bus.err_timeout && e_cyc < 0) e_cyc = c;
         if (bus.data_stb) strobes++;
      end
      check_val("t5_tmo_cycle", e_cyc, TMO + 1);
      check_val("t5_no_restrobe", strobes, 0);
      check_val("t5_din_hold", int'(bus.data_in), 33);
      drive(0, 0, 0, 0, 0); step();
      drive(0, 0, 0, 1, 0);
      strobes = 0; last_din = -1;
      for (int i = 0; i < 5; i++) begin
         step();
         if (bus.data_stb) begin
            strobes++;
            last_din = int'(bus.data_in);
         end
      end
      check_val("t5_toggle_stb", strobes, 1);
      check_val("t5_toggle_din", last_din, 44);
      drive(0, 0, 0, 0, 1); step();
      check_val("t5_clr", int'(bus.err_timeout), 0);
      drive(0, 0, 0, 1, 0); repeat (3) step();

      // flush during WAIT_ACK with four entries queued
      for (int i = 0; i < 5; i++) begin
         drive(1, 20 + i, 0, 1, 0); step();
      end
      check_val("t6_level4", int'(bus.host_level), 4);
      drive(0, 0, 1, 1, 0); step();
      check_val("t6_flush_level", int'(bus.host_level), 0);
      check_val("t6_busy_inflight", int'(bus.busy), 1);
      strobes = 0;
      for (int i = 0; i < 23; i++) begin
         drive(0, 0, 0, (i >= 3), 0); step();
         if (bus.data_stb) strobes++;
      end
      check_val("t6_no_stb", strobes, 0);
      check_val("t6_busy_end", int'(bus.busy), 0);
      drive(1, 9, 1, 0, 0); step();
      check_val("t6_flush_wr", int'(bus.host_level), 0);

      // random soak
      l = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 9) == 0) l = !l;
         drive((i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0),
               $urandom_range(0, 63),
               $urandom_range(0, 59) == 0,
               l,
               $urandom_range(0, 19) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
